// File: rtl/inst_fetch.sv
// Instruction fetch stage: streams a block of imem words into a small first-word-fall-through FIFO.
// Reads are credit-limited so decoder backpressure never drops or duplicates a word.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for i_start; base address and count latched here
// S_FETCH | issuing imem reads while FIFO credit is available
// S_DRAIN | all reads issued; waiting for the decoder to take the rest
// S_DONE  | one-cycle completion pulse, then back to S_IDLE
module inst_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_num_inst,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_imem_read_req,
  output logic [ADDR_WIDTH-1:0] o_imem_read_addr,
  input  logic [DATA_WIDTH-1:0] i_imem_read_data,
  output logic                  o_inst_valid,
  output logic [DATA_WIDTH-1:0] o_inst_data,
  input  logic                  i_inst_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   issue_left;
  logic [ADDR_WIDTH:0]   accept_left;
  logic                  inflight;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_count;
  logic                  push;
  logic                  pop;

  // Credit counts the in-flight word so the FIFO can never overflow.
  assign o_imem_read_req  = (state == S_FETCH) && (issue_left != '0) &&
                            ((fifo_count + CW'(inflight)) < DEPTH_C);
  assign o_imem_read_addr = addr;

  assign push         = inflight;
  assign o_inst_valid = (fifo_count != '0);
  assign pop          = o_inst_valid && i_inst_ready;
  assign o_inst_data  = o_inst_valid ? fifo_mem[rd_ptr] : '0;

  assign o_busy = (state != S_IDLE);
  assign o_done = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= 1'b0;
    end else begin
      inflight <= o_imem_read_req;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= i_imem_read_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      addr        <= '0;
      issue_left  <= '0;
      accept_left <= '0;
    end else begin
      if (pop) accept_left <= accept_left - 1'b1;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            addr        <= i_base_addr;
            issue_left  <= i_num_inst;
            accept_left <= i_num_inst;
            state       <= (i_num_inst == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (o_imem_read_req) begin
            addr       <= addr + 1'b1;
            issue_left <= issue_left - 1'b1;
            if (issue_left == (ADDR_WIDTH+1)'(1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && accept_left == (ADDR_WIDTH+1)'(1)) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: stimulus queues expected read addresses and words,
// a negedge monitor pops and compares whenever the DUT issues a read or hands over a word.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [6:0]  i_base_addr;
  logic [7:0]  i_num_inst;
  logic        o_busy;
  logic        o_done;
  logic        o_imem_read_req;
  logic [6:0]  o_imem_read_addr;
  logic [31:0] i_imem_read_data;
  logic        o_inst_valid;
  logic [31:0] o_inst_data;
  logic        i_inst_ready;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk              (clk),
    .reset            (reset),
    .i_start          (i_start),
    .i_base_addr      (i_base_addr),
    .i_num_inst       (i_num_inst),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_imem_read_req  (o_imem_read_req),
    .o_imem_read_addr (o_imem_read_addr),
    .i_imem_read_data (i_imem_read_data),
    .o_inst_valid     (o_inst_valid),
    .o_inst_data      (o_inst_data),
    .i_inst_ready     (i_inst_ready)
  );

  logic [31:0] mem [128];
  int          exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;
  int reads    = 0;
  int accepts  = 0;
  int outstanding = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

  // Data is only meaningful the cycle after a request; otherwise drive a poison pattern.
  always @(posedge clk)
    i_imem_read_data <= o_imem_read_req ? mem[o_imem_read_addr] : 32'hBAD0_BAD0;

  initial begin
    i_inst_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       i_inst_ready = ($urandom_range(0, 1) == 1);
        2:       i_inst_ready = 1'b0;
        default: i_inst_ready = 1'b1;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      outstanding = 0;
    end else begin
      if (o_done) done_cnt++;
      if (o_imem_read_req) begin
        reads++;
        outstanding++;
        if (exp_addr_q.size() == 0) check("unexpected_read", 64'(o_imem_read_addr) | 64'h100, 64'h0);
        else check("read_addr", 64'(o_imem_read_addr), 64'(exp_addr_q.pop_front()));
      end
      if (o_inst_valid && i_inst_ready) begin
        accepts++;
        outstanding--;
        if (exp_data_q.size() == 0) check("unexpected_word", 64'(o_inst_data) | 64'h1_0000_0000, 64'h0);
        else check("inst_data", 64'(o_inst_data), 64'(exp_data_q.pop_front()));
      end
      if (o_imem_read_req) check("fifo_occupancy", 64'(outstanding <= 4), 64'h1);
      if (!o_inst_valid) check("empty_data_zero", 64'(o_inst_data), 64'h0);
    end
  end

  task automatic start_block(input int base, input int num);
    for (int i = 0; i < num; i++) begin
      int a;
      a = (base + i) % 128;
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem[a]);
    end
    i_start     = 1'b1;
    i_base_addr = 7'(base);
    i_num_inst  = 8'(num);
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("block_timeout", 64'(o_busy), 64'h0);
  endtask

  task automatic end_block(input string name, input int d0);
    wait_idle();
    @(posedge clk);
    #1;
    check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'h1);
    check({name, "_addr_q_empty"}, 64'(exp_addr_q.size()), 64'h0);
    check({name, "_data_q_empty"}, 64'(exp_data_q.size()), 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, r0, a0, n;
    for (int i = 0; i < 128; i++) mem[i] = {8'hA5, 8'(i), 8'h5A, ~8'(i)};
    reset = 1'b1;
    i_start = 1'b0;
    i_base_addr = '0;
    i_num_inst = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(o_busy), 64'h0);
    check("rst_done", 64'(o_done), 64'h0);
    check("rst_req", 64'(o_imem_read_req), 64'h0);
    check("rst_addr", 64'(o_imem_read_addr), 64'h0);
    check("rst_valid", 64'(o_inst_valid), 64'h0);
    check("rst_data", 64'(o_inst_data), 64'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: basic block, latency of first request and first valid word
    d0 = done_cnt;
    start_block(0, 5);
    check("t1_req_c1", 64'(o_imem_read_req), 64'h1);
    check("t1_busy_c1", 64'(o_busy), 64'h1);
    check("t1_valid_c1", 64'(o_inst_valid), 64'h0);
    @(posedge clk); #1;
    check("t1_valid_c2", 64'(o_inst_valid), 64'h0);
    @(posedge clk); #1;
    check("t1_valid_c3", 64'(o_inst_valid), 64'h1);
    check("t1_data_c3", 64'(o_inst_data), 64'(32'hA500_5AFF));
    end_block("t1", d0);

    // 2: address wrap
    d0 = done_cnt;
    start_block(126, 4);
    end_block("t2", d0);

    // 3: stalled decoder, only FIFO_DEPTH reads; mid-block start must be ignored
    ready_mode = 2;
    i_inst_ready = 1'b0;
    @(posedge clk); #1;
    d0 = done_cnt;
    r0 = reads;
    start_block(5, 8);
    repeat (4) @(posedge clk);
    #1;
    i_start = 1'b1; i_base_addr = 7'd99; i_num_inst = 8'd3;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("t3_stall_reads", 64'(reads - r0), 64'h4);
    check("t3_stall_valid", 64'(o_inst_valid), 64'h1);
    ready_mode = 0;
    end_block("t3", d0);

    // 4: whole memory with random backpressure
    ready_mode = 1;
    d0 = done_cnt;
    r0 = reads;
    start_block(37, 128);
    end_block("t4", d0);
    check("t4_reads", 64'(reads - r0), 64'd128);
    ready_mode = 0;
    @(posedge clk); #1;

    // 5: empty block
    d0 = done_cnt;
    start_block(3, 0);
    check("t5_busy_c1", 64'(o_busy), 64'h1);
    check("t5_done_c1", 64'(o_done), 64'h1);
    check("t5_req_c1", 64'(o_imem_read_req), 64'h0);
    @(posedge clk); #1;
    check("t5_busy_c2", 64'(o_busy), 64'h0);
    check("t5_done_c2", 64'(o_done), 64'h0);
    check("t5_done_pulses", 64'(done_cnt - d0), 64'h1);

    // 6: reset in the middle of a block, then a fresh block
    d0 = done_cnt;
    a0 = accepts;
    start_block(20, 10);
    n = 0;
    while ((accepts - a0) < 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_reached_3", 64'((accepts - a0) >= 3), 64'h1);
    reset = 1'b1;
    #1;
    check("t6_rst_busy", 64'(o_busy), 64'h0);
    check("t6_rst_done", 64'(o_done), 64'h0);
    check("t6_rst_req", 64'(o_imem_read_req), 64'h0);
    check("t6_rst_addr", 64'(o_imem_read_addr), 64'h0);
    check("t6_rst_valid", 64'(o_inst_valid), 64'h0);
    check("t6_rst_data", 64'(o_inst_data), 64'h0);
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("t6_no_done", 64'(done_cnt - d0), 64'h0);
    d0 = done_cnt;
    start_block(10, 2);
    end_block("t6b", d0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
